mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates between an instruction fetch port and a data port onto a single RAM port.
// Data accesses take priority unless fetch has been starved for three data grants in a row.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    input  logic        halt,
    input  logic [31:0] ramload,
    input  logic        ram_ready,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        iwait,
    output logic        dwait,
    output logic        err
);

    // state   | meaning
    // IDLE    | no RAM access; arbitrate and latch the winner on exit
    // IFETCH  | RAM read on behalf of the fetch stage
    // DACCESS | RAM read or write on behalf of the data stage
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IFETCH  = 2'd1,
        DACCESS = 2'd2
    } state_t;

    // Down-counter loaded on grant; reaching zero without ram_ready means TIMEOUT access cycles elapsed.
    localparam logic [7:0] TMR_LOAD = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [1:0]  starve_q, starve_d;
    logic [7:0]  tmr_q, tmr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] store_q, store_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        err_q, err_d;

    logic data_req;
    logic fetch_ok;
    logic starve_fetch;

    assign data_req     = dREN | dWEN;
    assign fetch_ok     = iREN & ~halt;
    assign starve_fetch = (starve_q == 2'd3) & fetch_ok;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            starve_q <= 2'd0;
            tmr_q    <= 8'd0;
            addr_q   <= 32'd0;
            store_q  <= 32'd0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            tmr_q    <= tmr_d;
            addr_q   <= addr_d;
            store_q  <= store_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        tmr_d    = tmr_q;
        addr_d   = addr_q;
        store_d  = store_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (data_req && !starve_fetch) begin
                    state_d = DACCESS;
                    addr_d  = daddr;
                    store_d = dstore;
                    // A simultaneous read and write request is treated as a write and flagged.
                    wr_d    = dWEN;
                    rd_d    = dREN & ~dWEN;
                    err_d   = err_q | (dREN & dWEN);
                    tmr_d   = TMR_LOAD;
                    if (!iREN) begin
                        starve_d = 2'd0;
                    end else if (starve_q != 2'd3) begin
                        starve_d = starve_q + 2'd1;
                    end
                end else if (fetch_ok) begin
                    state_d  = IFETCH;
                    addr_d   = iaddr;
                    store_d  = 32'd0;
                    rd_d     = 1'b1;
                    wr_d     = 1'b0;
                    tmr_d    = TMR_LOAD;
                    starve_d = 2'd0;
                end
            end
            IFETCH, DACCESS: begin
                if (ram_ready) begin
                    state_d = IDLE;
                end else if (tmr_q == 8'd0) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    tmr_d = tmr_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        iload    = 32'd0;
        dload    = 32'd0;
        iwait    = iREN;
        dwait    = data_req;

        case (state_q)
            IFETCH: begin
                ramREN  = 1'b1;
                ramaddr = addr_q;
                if (ram_ready) begin
                    iwait = 1'b0;
                    iload = ramload;
                end
            end
            DACCESS: begin
                ramREN   = rd_q;
                ramWEN   = wr_q;
                ramaddr  = addr_q;
                ramstore = store_q;
                if (ram_ready) begin
                    dwait = 1'b0;
                    dload = ramload;
                end
            end
            default: begin
            end
        endcase
    end

    assign err = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        iREN = 1'b0;
    logic [31:0] iaddr = 32'd0;
    logic        dREN = 1'b0;
    logic        dWEN = 1'b0;
    logic [31:0] daddr = 32'd0;
    logic [31:0] dstore = 32'd0;
    logic        halt = 1'b0;
    logic [31:0] ramload = 32'd0;
    logic        ram_ready = 1'b0;
    logic        ramREN, ramWEN, iwait, dwait, err;
    logic [31:0] ramaddr, ramstore, iload, dload;

    int checks = 0;
    int errors = 0;

    mem_arbiter dut (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .halt(halt), .ramload(ramload), .ram_ready(ram_ready),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .iload(iload), .dload(dload), .iwait(iwait), .dwait(dwait), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic clear_inputs();
        iREN = 0; iaddr = 0; dREN = 0; dWEN = 0; daddr = 0; dstore = 0;
        halt = 0; ramload = 0; ram_ready = 0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1;
        clear_inputs();
        @(negedge CLK);
        @(negedge CLK);
        RST = 0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RST = 1; iREN = 1; dREN = 1; ram_ready = 1;
        #1;
        checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL reset_ramREN: got %b exp 0", ramREN); end
        checks++; if (ramWEN !== 1'b0) begin errors++; $display("FAIL reset_ramWEN: got %b exp 0", ramWEN); end
        checks++; if (ramaddr !== 32'd0) begin errors++; $display("FAIL reset_ramaddr: got %h exp 0", ramaddr); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", err); end
        checks++; if ({iwait, dwait} !== 2'b11) begin errors++; $display("FAIL reset_waits: got %b exp 11", {iwait, dwait}); end
        @(negedge CLK); @(negedge CLK);
        checks++; if (ramREN !== 1'b0 || dload !== 32'd0 || iload !== 32'd0) begin
            errors++; $display("FAIL reset_held_idle: got ren=%b dload=%h iload=%h exp 0", ramREN, dload, iload);
        end
        RST = 0;
        clear_inputs();
    endtask

    task automatic test_single_fetch();
        do_reset();
        iREN = 1; iaddr = 32'h40;
        #2;
        checks++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin errors++; $display("FAIL fetch_idle: got ren=%b iwait=%b exp 0/1", ramREN, iwait); end
        @(negedge CLK); #2;
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h40) begin errors++; $display("FAIL fetch_ram: got ren=%b addr=%h exp 1/40", ramREN, ramaddr); end
        checks++; if (iwait !== 1'b1 || iload !== 32'd0) begin errors++; $display("FAIL fetch_wait: got iwait=%b iload=%h exp 1/0", iwait, iload); end
        @(negedge CLK);
        ram_ready = 1; ramload = 32'h1234_5678;
        #2;
        checks++; if (iwait !== 1'b0 || iload !== 32'h1234_5678) begin errors++; $display("FAIL fetch_done: got iwait=%b iload=%h exp 0/12345678", iwait, iload); end
        @(negedge CLK);
        iREN = 0;
        #2;
        checks++; if (ramREN !== 1'b0 || iload !== 32'd0) begin errors++; $display("FAIL fetch_back_idle: got ren=%b iload=%h exp 0/0", ramREN, iload); end
        clear_inputs();
    endtask

    task automatic test_simultaneous();
        do_reset();
        iREN = 1; iaddr = 32'h100; dWEN = 1; daddr = 32'h80; dstore = 32'hDEAD; ram_ready = 1; ramload = 32'hCAFE;
        #2;
        checks++; if (ramWEN !== 1'b0 || {iwait, dwait} !== 2'b11) begin errors++; $display("FAIL simul_idle: got wen=%b waits=%b exp 0/11", ramWEN, {iwait, dwait}); end
        @(negedge CLK); #2;
        checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h80 || ramstore !== 32'hDEAD) begin
            errors++; $display("FAIL simul_write: got wen=%b ren=%b addr=%h store=%h exp 1/0/80/dead", ramWEN, ramREN, ramaddr, ramstore);
        end
        checks++; if (dwait !== 1'b0 || dload !== 32'hCAFE || iwait !== 1'b1) begin
            errors++; $display("FAIL simul_dwait: got dwait=%b dload=%h iwait=%b exp 0/cafe/1", dwait, dload, iwait);
        end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL simul_err: got %b exp 0", err); end
        @(negedge CLK);
        dWEN = 0;
        #2;
        checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || iwait !== 1'b1) begin errors++; $display("FAIL simul_bubble: got ren=%b wen=%b iwait=%b exp 0/0/1", ramREN, ramWEN, iwait); end
        @(negedge CLK); #2;
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h100 || iwait !== 1'b0) begin errors++; $display("FAIL simul_fetch: got ren=%b addr=%h iwait=%b exp 1/100/0", ramREN, ramaddr, iwait); end
        @(negedge CLK);
        clear_inputs();
    endtask

    task automatic test_starvation();
        int ngrant = 0;
        do_reset();
        iREN = 1; iaddr = 32'h10; dREN = 1; daddr = 32'hD0; ram_ready = 1;
        for (int c = 0; c < 16; c++) begin
            #2;
            if (ramREN === 1'b1) begin
                logic [31:0] exp_addr;
                exp_addr = (ngrant % 4 == 3) ? 32'h10 : 32'hD0;
                checks++; if (ramaddr !== exp_addr) begin errors++; $display("FAIL starve_grant%0d: got addr=%h exp %h", ngrant, ramaddr, exp_addr); end
                ngrant++;
            end
            @(negedge CLK);
        end
        checks++; if (ngrant !== 8) begin errors++; $display("FAIL starve_count: got %0d grants exp 8", ngrant); end
        clear_inputs();
    endtask

    task automatic test_timeout();
        int cnt = 0;
        do_reset();
        dREN = 1; daddr = 32'h44; ram_ready = 0;
        @(negedge CLK); #2;
        while (ramREN === 1'b1 && cnt < 300) begin
            if (cnt == 253) begin
                checks++; if (err !== 1'b0) begin errors++; $display("FAIL timeout_early_err: got %b exp 0", err); end
            end
            cnt++;
            @(negedge CLK); #2;
        end
        checks++; if (cnt !== 255) begin errors++; $display("FAIL timeout_cycles: got %0d exp 255", cnt); end
        checks++; if (err !== 1'b1 || dwait !== 1'b1 || ramREN !== 1'b0) begin
            errors++; $display("FAIL timeout_abort: got err=%b dwait=%b ren=%b exp 1/1/0", err, dwait, ramREN);
        end
        ram_ready = 1; ramload = 32'h77;
        @(negedge CLK); #2;
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h44 || dwait !== 1'b0 || dload !== 32'h77) begin
            errors++; $display("FAIL timeout_retry: got ren=%b addr=%h dwait=%b dload=%h exp 1/44/0/77", ramREN, ramaddr, dwait, dload);
        end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b exp 1", err); end
        @(negedge CLK);
        clear_inputs();
    endtask

    task automatic test_halt();
        do_reset();
        halt = 1; iREN = 1; iaddr = 32'h20; ram_ready = 1;
        for (int c = 0; c < 6; c++) begin
            #2;
            checks++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin errors++; $display("FAIL halt_nofetch%0d: got ren=%b iwait=%b exp 0/1", c, ramREN, iwait); end
            @(negedge CLK);
        end
        dREN = 1; daddr = 32'h300;
        @(negedge CLK); #2;
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h300 || dwait !== 1'b0) begin
            errors++; $display("FAIL halt_data: got ren=%b addr=%h dwait=%b exp 1/300/0", ramREN, ramaddr, dwait);
        end
        @(negedge CLK);
        clear_inputs();
        do_reset();
        iREN = 1; iaddr = 32'h200;
        @(negedge CLK);
        halt = 1;
        #2;
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h200) begin errors++; $display("FAIL halt_inflight: got ren=%b addr=%h exp 1/200", ramREN, ramaddr); end
        @(negedge CLK);
        ram_ready = 1; ramload = 32'hABCD;
        #2;
        checks++; if (iwait !== 1'b0 || iload !== 32'hABCD) begin errors++; $display("FAIL halt_complete: got iwait=%b iload=%h exp 0/abcd", iwait, iload); end
        @(negedge CLK);
        clear_inputs();
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        dREN = 1; dWEN = 1; daddr = 32'h500; dstore = 32'hBEEF;
        #2;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL both_pre_err: got %b exp 0", err); end
        @(negedge CLK); #2;
        checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'hBEEF || err !== 1'b1) begin
            errors++; $display("FAIL both_write: got wen=%b ren=%b store=%h err=%b exp 1/0/beef/1", ramWEN, ramREN, ramstore, err);
        end
        RST = 1;
        #1;
        checks++; if (ramWEN !== 1'b0 || ramREN !== 1'b0 || ramaddr !== 32'd0 || err !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs: got wen=%b ren=%b addr=%h err=%b exp 0/0/0/0", ramWEN, ramREN, ramaddr, err);
        end
        checks++; if (dwait !== 1'b1 || dload !== 32'd0) begin errors++; $display("FAIL midrst_dwait: got dwait=%b dload=%h exp 1/0", dwait, dload); end
        @(negedge CLK);
        RST = 0; dREN = 0; dWEN = 0; iREN = 1; iaddr = 32'h600; ram_ready = 1;
        #2;
        checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL midrst_idle: got ren=%b exp 0", ramREN); end
        @(negedge CLK); #2;
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h600 || iwait !== 1'b0) begin
            errors++; $display("FAIL midrst_restart: got ren=%b addr=%h iwait=%b exp 1/600/0", ramREN, ramaddr, iwait);
        end
        @(negedge CLK);
        clear_inputs();
    endtask

    // Reference model: tracks the transaction in flight (none/fetch/data), how long it has run,
    // how many data grants in a row went past a pending fetch, and the sticky error.
    task automatic test_random(input int n);
        int          busy = 0;
        int          elapsed = 0;
        int          streak = 0;
        logic [31:0] m_addr = 0, m_store = 0;
        logic        m_rd = 0, m_wr = 0, m_err = 0;
        bit          i_act = 0, d_act = 0;
        logic        e_ren, e_wen, e_iw, e_dw;
        logic [31:0] e_addr, e_store, e_il, e_dl;
        do_reset();
        for (int k = 0; k < n; k++) begin
            if (!i_act && $urandom_range(0, 2) == 0) begin
                i_act = 1; iaddr = $urandom;
            end else if (i_act && $urandom_range(0, 39) == 0) begin
                i_act = 0;
            end
            if (!d_act && $urandom_range(0, 2) == 0) begin
                int op;
                op = $urandom_range(0, 15);
                d_act = 1; daddr = $urandom; dstore = $urandom;
                dWEN = (op < 6) || (op == 15);
                dREN = (op >= 6);
            end else if (d_act && $urandom_range(0, 39) == 0) begin
                d_act = 0;
            end
            iREN = i_act;
            if (!d_act) begin dREN = 0; dWEN = 0; end
            if ($urandom_range(0, 7) == 0) halt = ~halt;
            ram_ready = ($urandom_range(0, 3) != 0);
            ramload = $urandom;
            #2;
            e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0; e_il = 0; e_dl = 0;
            e_iw = iREN; e_dw = dREN | dWEN;
            if (busy == 1) begin
                e_ren = 1; e_addr = m_addr;
                if (ram_ready) begin e_iw = 0; e_il = ramload; end
            end else if (busy == 2) begin
                e_ren = m_rd; e_wen = m_wr; e_addr = m_addr; e_store = m_store;
                if (ram_ready) begin e_dw = 0; e_dl = ramload; end
            end
            checks++; if ({ramREN, ramWEN} !== {e_ren, e_wen}) begin errors++; $display("FAIL rnd_strobes@%0d: got %b exp %b", k, {ramREN, ramWEN}, {e_ren, e_wen}); end
            checks++; if (ramaddr !== e_addr) begin errors++; $display("FAIL rnd_addr@%0d: got %h exp %h", k, ramaddr, e_addr); end
            if (busy != 1) begin
                checks++; if (ramstore !== e_store) begin errors++; $display("FAIL rnd_store@%0d: got %h exp %h", k, ramstore, e_store); end
            end
            checks++; if ({iwait, dwait} !== {e_iw, e_dw}) begin errors++; $display("FAIL rnd_waits@%0d: got %b exp %b", k, {iwait, dwait}, {e_iw, e_dw}); end
            checks++; if (iload !== e_il) begin errors++; $display("FAIL rnd_iload@%0d: got %h exp %h", k, iload, e_il); end
            checks++; if (dload !== e_dl) begin errors++; $display("FAIL rnd_dload@%0d: got %h exp %h", k, dload, e_dl); end
            checks++; if (err !== m_err) begin errors++; $display("FAIL rnd_err@%0d: got %b exp %b", k, err, m_err); end
            if (i_act && !e_iw) i_act = 0;
            if (d_act && !e_dw) d_act = 0;
            if (busy == 0) begin
                bit want_i;
                want_i = iREN && !halt;
                if ((dREN || dWEN) && !(streak >= 3 && want_i)) begin
                    busy = 2; elapsed = 0;
                    m_addr = daddr; m_store = dstore; m_wr = dWEN; m_rd = dREN && !dWEN;
                    if (dREN && dWEN) m_err = 1;
                    streak = iREN ? ((streak < 3) ? streak + 1 : 3) : 0;
                end else if (want_i) begin
                    busy = 1; elapsed = 0; m_addr = iaddr; streak = 0;
                end
            end else begin
                elapsed++;
                if (ram_ready) busy = 0;
                else if (elapsed == 255) begin busy = 0; m_err = 1; end
            end
            @(negedge CLK);
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_starvation();
        test_timeout();
        test_halt();
        test_reset_mid_access();
        test_random(3000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
